// File: rtl/ultrasonic_echo_responder_pkg.sv
// rtl/ultrasonic_echo_responder_pkg.sv - shared state encoding and timing helpers
package ultrasonic_echo_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int unsigned US_PER_CM_DEFAULT = 58;

    // Clock cycles per microsecond; CLK_HZ is expected to be a whole number of MHz.
    function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ultrasonic_echo_responder_if.sv
// rtl/ultrasonic_echo_responder_if.sv - trigger/echo ranging link between initiator and responder
interface ultrasonic_echo_responder_if;
    logic        trigger;
    logic [15:0] distance_cm;
    logic        echo;
    logic        busy;
    logic        short_trig;
    logic [15:0] latched_cm;

    modport master (
        output trigger, distance_cm,
        input  echo, busy, short_trig, latched_cm
    );

    modport slave (
        input  trigger, distance_cm,
        output echo, busy, short_trig, latched_cm
    );
endinterface

// File: rtl/ultrasonic_echo_responder_us_tick_gen.sv
// rtl/ultrasonic_echo_responder_us_tick_gen.sv - microsecond prescaler with synchronous restart
module us_tick_gen #(
    parameter int unsigned CYC_PER_US = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // Count 0..CYC_PER_US-1, wrapping on the tick; clear restarts the microsecond.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ultrasonic_echo_responder.sv
// rtl/ultrasonic_echo_responder.sv - HC-SR04 style responder: validates trigger, returns timed echo
module ultrasonic_echo_responder
    import ultrasonic_echo_responder_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 250,
    parameter int unsigned US_PER_CM   = US_PER_CM_DEFAULT,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic                         clk,
    input  logic                         reset,
    ultrasonic_echo_responder_if.slave   bus
);
    localparam int unsigned CYC_PER_US = cyc_per_us(CLK_HZ);
    localparam logic [15:0] TRIG_MIN   = 16'(TRIG_MIN_US);
    localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] MAX_D      = 16'(MAX_CM);

    state_t      state_q, state_d;
    logic        trig_s1_q, trig_s1_d, trig_s2_q, trig_s2_d, trig_prev_q, trig_prev_d;
    logic        vld1_q, vld1_d, vld2_q, vld2_d, arm_q, arm_d;
    logic [15:0] us_cnt_q, us_cnt_d;
    logic        echo_q, echo_d, busy_q, busy_d, short_q, short_d;
    logic [15:0] latched_q, latched_d;
    logic        tick, state_chg, rise, fall, echo_done;
    logic [31:0] echo_w;

    us_tick_gen #(.CYC_PER_US(CYC_PER_US)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_chg),
        .tick  (tick)
    );

    // A rise only counts once the synchronizer has shown trigger low after reset,
    // so a trigger held high through reset release is not mistaken for a request.
    assign rise = arm_q & trig_s2_q & ~trig_prev_q;
    assign fall = trig_prev_q & ~trig_s2_q;

    // Out-of-range distances select the timeout constant, bypassing the product.
    assign echo_w    = (latched_q >= 16'd1 && latched_q <= MAX_D) ?
                       32'(latched_q) * 32'(US_PER_CM) : 32'(TIMEOUT_US);
    assign echo_done = tick && ({16'd0, us_cnt_q} == echo_w - 32'd1);
    assign state_chg = (state_d != state_q);

    // Synchronizer, edge history and post-reset arming.
    always_comb begin
        trig_s1_d   = bus.trigger;
        trig_s2_d   = trig_s1_q;
        trig_prev_d = trig_s2_q;
        vld1_d      = 1'b1;
        vld2_d      = vld1_q;
        arm_d       = arm_q | (vld2_q & ~trig_s2_q);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rise) state_d = ST_TRIG_HI;
            ST_TRIG_HI: if (fall) state_d = (us_cnt_q >= TRIG_MIN) ? ST_BURST : ST_IDLE;
            ST_BURST:   if (tick && us_cnt_q == BURST_LAST) state_d = ST_ECHO;
            ST_ECHO:    if (echo_done) state_d = ST_HOLDOFF;
            ST_HOLDOFF: if (tick && us_cnt_q == HOLD_LAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Microsecond counter: clears on any state change, saturates at TRIG_MIN in TRIG_HI.
    always_comb begin
        us_cnt_d = us_cnt_q;
        if (state_chg) begin
            us_cnt_d = '0;
        end else if (tick) begin
            if (state_q == ST_TRIG_HI) begin
                if (us_cnt_q < TRIG_MIN) us_cnt_d = us_cnt_q + 16'd1;
            end else if (us_cnt_q != 16'hFFFF) begin
                us_cnt_d = us_cnt_q + 16'd1;
            end
        end
    end

    // Registered outputs, derived from the state being entered.
    always_comb begin
        echo_d    = (state_d == ST_ECHO);
        busy_d    = (state_d == ST_BURST) || (state_d == ST_ECHO) || (state_d == ST_HOLDOFF);
        short_d   = (state_q == ST_TRIG_HI) && fall && (us_cnt_q < TRIG_MIN);
        latched_d = latched_q;
        if (state_q == ST_TRIG_HI && state_d == ST_BURST) begin
            latched_d = bus.distance_cm;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            arm_q       <= 1'b0;
            us_cnt_q    <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            short_q     <= 1'b0;
            latched_q   <= '0;
        end else begin
            trig_s1_q   <= trig_s1_d;
            trig_s2_q   <= trig_s2_d;
            trig_prev_q <= trig_prev_d;
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
            arm_q       <= arm_d;
            us_cnt_q    <= us_cnt_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            short_q     <= short_d;
            latched_q   <= latched_d;
        end
    end

    assign bus.echo       = echo_q;
    assign bus.busy       = busy_q;
    assign bus.short_trig = short_q;
    assign bus.latched_cm = latched_q;
endmodule
